// File: rtl/board_renderer.sv
// Minesweeper play-field renderer: loads board geometry over a settings handshake,
// then draws each field from its state word with a fixed two-stage pixel pipeline.
package color_pkg;
  localparam logic [11:0] BUTTON_BACK   = 12'hBBB;
  localparam logic [11:0] BUTTON_WHITE  = 12'hFFF;
  localparam logic [11:0] BUTTON_GRAY   = 12'h777;
  localparam logic [11:0] FLAG_RED      = 12'hF00;
  localparam logic [11:0] REVEALED_GRAY = 12'hCCC;
  localparam logic [11:0] MINE_BLACK    = 12'h000;
  localparam logic [11:0] NUMBER_BLUE   = 12'h00F;
endpackage

interface vga_if #(parameter int XY_W = 11, parameter int RGB_W = 12) ();
  logic [XY_W-1:0]  vcount, hcount;
  logic             vsync, vblnk, hsync, hblnk;
  logic [RGB_W-1:0] rgb;
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

module board_renderer
  import color_pkg::*;
#(
  parameter int MAX_COLS = 16,
  parameter int MAX_ROWS = 16,
  parameter int MARGIN   = 5,
  parameter int XY_W     = 11,
  parameter int RGB_W    = 12,
  parameter int SET_AW   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  vga_if.in                                     in,
  vga_if.out                                    out,
  output logic                                  set_req,
  output logic [SET_AW-1:0]                     set_addr,
  input  logic [15:0]                           set_rdata,
  input  logic                                  set_ack,
  output logic [$clog2(MAX_COLS*MAX_ROWS)-1:0]  fld_addr,
  input  logic [5:0]                            fld_data,
  output logic                                  busy
);
  localparam int FA_W = $clog2(MAX_COLS*MAX_ROWS);
  localparam int CW   = $clog2(MAX_COLS+1);
  localparam int RW   = $clog2(MAX_ROWS+1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d, calc_q, calc_d;
  logic [SET_AW-1:0] addr_q, addr_d;
  logic [1:0]        idx_q, idx_d;
  logic [XY_W-1:0]   xpos_q, xpos_d, ypos_q, ypos_d;
  logic [5:0]        fs_q, fs_d;
  logic [7:0]        cols_q, cols_d, rows_q, rows_d;
  logic [13:0]       bw_q, bw_d, bh_q, bh_d;

  function automatic logic [7:0] clamp_dim(input logic [7:0] v, input int mx);
    if (v == 8'd0) return 8'd1;
    if (32'(v) > 32'(mx)) return 8'(mx);
    return v;
  endfunction

  // ---------------- settings loader FSM ----------------
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    calc_d  = 1'b0;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    fs_d    = fs_q;
    cols_d  = cols_q;
    rows_d  = rows_q;
    bw_d    = bw_q;
    bh_d    = bh_q;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (enable) begin
          state_d = LOAD;
          req_d   = 1'b1;
          addr_d  = '0;
          idx_d   = '0;
          xpos_d  = '0;
          ypos_d  = '0;
          fs_d    = '0;
          cols_d  = '0;
          rows_d  = '0;
          bw_d    = '0;
          bh_d    = '0;
        end
      end
      LOAD: begin
        // abort outranks a same-cycle acknowledge
        if (!enable) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (calc_q) begin
          bw_d    = 14'(cols_q) * 14'(fs_q);
          bh_d    = 14'(rows_q) * 14'(fs_q);
          state_d = DRAW;
        end else if (req_q && set_ack) begin
          case (idx_q)
            2'd0:    xpos_d = set_rdata[XY_W-1:0];
            2'd1:    ypos_d = set_rdata[XY_W-1:0];
            2'd2:    fs_d   = set_rdata[5:0];
            default: begin
              cols_d = clamp_dim(set_rdata[7:0],  MAX_COLS);
              rows_d = clamp_dim(set_rdata[15:8], MAX_ROWS);
            end
          endcase
          if (idx_q == 2'd3) begin
            req_d  = 1'b0;
            calc_d = 1'b1;
          end else begin
            idx_d  = idx_q + 2'd1;
            addr_d = addr_q + SET_AW'(2);
          end
        end
      end
      default: begin
        req_d = 1'b0;
        if (!enable) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      calc_q  <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      fs_q    <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
      bw_q    <= '0;
      bh_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      calc_q  <= calc_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      fs_q    <= fs_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
      bw_q    <= bw_d;
      bh_q    <= bh_d;
    end
  end

  assign set_req  = req_q;
  assign set_addr = addr_q;
  assign busy     = (state_q == LOAD);

  // ---------------- stage 1: field tracking ----------------
  logic [5:0]       px_q, px_d, py_q, py_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             h_in, v_in, inside_q, inside_d;
  logic [FA_W-1:0]  fa_q, fa_d;
  logic [XY_W-1:0]  hc_q, vc_q;
  logic             hs_q, vs_q, hb_q, vb_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  assign h_in = (32'(in.hcount) >= 32'(xpos_q)) &&
                (32'(in.hcount) <  32'(xpos_q) + 32'(bw_q));
  assign v_in = (32'(in.vcount) >= 32'(ypos_q)) &&
                (32'(in.vcount) <  32'(ypos_q) + 32'(bh_q));

  // px/py are the in-field offsets of the pixel entering the pipe; no division needed
  always_comb begin
    px_d  = px_q;
    col_d = col_q;
    py_d  = py_q;
    row_d = row_q;
    if (in.hcount == xpos_q) begin
      px_d  = '0;
      col_d = '0;
    end else if (h_in) begin
      if (px_q == fs_q - 6'd1) begin
        px_d  = '0;
        col_d = col_q + CW'(1);
      end else begin
        px_d  = px_q + 6'd1;
      end
    end
    if (in.hcount == '0) begin
      if (in.vcount == ypos_q) begin
        py_d  = '0;
        row_d = '0;
      end else if (v_in) begin
        if (py_q == fs_q - 6'd1) begin
          py_d  = '0;
          row_d = row_q + RW'(1);
        end else begin
          py_d  = py_q + 6'd1;
        end
      end
    end
    inside_d = (state_q == DRAW) && h_in && v_in;
    fa_d     = inside_d ? FA_W'(32'(row_d) * 32'(MAX_COLS) + 32'(col_d)) : fa_q;
  end

  // ---------------- stage 2: colour select ----------------
  logic px_int, py_int, interior;

  always_comb begin
    // both bounds failing for small fields means no interior exists
    px_int   = (32'(px_q) >= 32'(MARGIN)) && (32'(px_q) + 32'(MARGIN) + 32'd1 <= 32'(fs_q));
    py_int   = (32'(py_q) >= 32'(MARGIN)) && (32'(py_q) + 32'(MARGIN) + 32'd1 <= 32'(fs_q));
    interior = px_int && py_int;
    rgb_d    = rgb_q;
    if (inside_q) begin
      if (fld_data[5]) begin
        if (!interior || fld_data[3:0] == 4'd0) rgb_d = RGB_W'(REVEALED_GRAY);
        else if (fld_data[3:0] == 4'd9)          rgb_d = RGB_W'(MINE_BLACK);
        else if (fld_data[3:0] <= 4'd8)          rgb_d = RGB_W'(NUMBER_BLUE);
        else                                     rgb_d = RGB_W'(REVEALED_GRAY);
      end else if (interior) begin
        rgb_d = fld_data[4] ? RGB_W'(FLAG_RED) : RGB_W'(BUTTON_BACK);
      end else if (px_q >= py_q) begin
        rgb_d = RGB_W'(BUTTON_WHITE);
      end else begin
        rgb_d = RGB_W'(BUTTON_GRAY);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_q       <= '0;
      py_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inside_q   <= 1'b0;
      fa_q       <= '0;
      hc_q       <= '0;
      vc_q       <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hb_q       <= 1'b0;
      vb_q       <= 1'b0;
      rgb_q      <= '0;
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      px_q       <= px_d;
      py_q       <= py_d;
      col_q      <= col_d;
      row_q      <= row_d;
      inside_q   <= inside_d;
      fa_q       <= fa_d;
      hc_q       <= in.hcount;
      vc_q       <= in.vcount;
      hs_q       <= in.hsync;
      vs_q       <= in.vsync;
      hb_q       <= in.hblnk;
      vb_q       <= in.vblnk;
      rgb_q      <= in.rgb;
      out.hcount <= hc_q;
      out.vcount <= vc_q;
      out.hsync  <= hs_q;
      out.vsync  <= vs_q;
      out.hblnk  <= hb_q;
      out.vblnk  <= vb_q;
      out.rgb    <= rgb_d;
    end
  end

  assign fld_addr = fa_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: reset, pass-through, settings load, field colours,
// clamping, board edge, abort and reset during load.
module tb_board_renderer;
  import color_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable, set_ack;
  logic [15:0] set_rdata;
  logic [5:0]  fld_data;
  logic        set_req, busy;
  logic [7:0]  set_addr, fld_addr;
  logic [7:0]  fa;
  int          checks = 0;
  int          errors = 0;

  vga_if #(.XY_W(11), .RGB_W(12)) vin ();
  vga_if #(.XY_W(11), .RGB_W(12)) vout ();

  board_renderer #(
    .MAX_COLS(16), .MAX_ROWS(16), .MARGIN(5), .XY_W(11), .RGB_W(12), .SET_AW(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in(vin), .out(vout),
    .set_req(set_req), .set_addr(set_addr), .set_rdata(set_rdata), .set_ack(set_ack),
    .fld_addr(fld_addr), .fld_data(fld_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plays the settings responder, acking each request after `waits` idle cycles.
  task automatic load(input logic [15:0] r0, input logic [15:0] r1,
                      input logic [15:0] r2, input logic [15:0] r3, input int waits);
    logic [15:0] regs [4];
    logic [7:0]  a;
    int          n;
    regs = '{r0, r1, r2, r3};
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!set_req && n < 20) begin tick(); n++; end
      check("load_req", set_req, 1);
      check("load_addr", set_addr, 8'(2*i));
      a = set_addr;
      for (int w = 0; w < waits; w++) tick();
      check("addr_stable", {set_req, set_addr}, {1'b1, a});
      check("busy_load", busy, 1);
      set_ack = 1'b1; set_rdata = regs[i];
      tick();
      set_ack = 1'b0; set_rdata = 16'h0;
    end
  endtask

  // Raster from board top (ypos 0x30) down to line v, then along line v to h.
  task automatic probe(input string tag, input int h, input int v,
                       input logic [11:0] exp, output logic [7:0] fa_o);
    for (int vv = 48; vv <= v; vv++) begin
      vin.vcount = 11'(vv); vin.hcount = 11'd0; tick();
    end
    for (int hh = 64; hh < h; hh++) begin
      vin.hcount = 11'(hh); tick();
    end
    vin.hcount = 11'(h);
    tick();
    fa_o = fld_addr;
    tick();
    check(tag, vout.rgb, exp);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; set_ack = 1'b0; set_rdata = 16'h0; fld_data = 6'h0;
    vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h555;
    repeat (3) tick();
    check("rst_rgb",  vout.rgb, 0);
    check("rst_req",  set_req, 0);
    check("rst_addr", set_addr, 0);
    check("rst_fa",   fld_addr, 0);
    check("rst_busy", busy, 0);

    rst = 1'b0; vin.rgb = 12'h123; vin.hcount = 11'd7; vin.hsync = 1'b1;
    tick();
    check("lat1_rgb", vout.rgb, 0);
    tick();
    check("pass_rgb", vout.rgb, 12'h123);
    check("pass_hc",  vout.hcount, 7);
    check("pass_hs",  vout.hsync, 1);
    check("idle_req", set_req, 0);

    set_ack = 1'b1; set_rdata = 16'hFFFF; tick(); set_ack = 1'b0;
    check("late_ack_busy", busy, 0);
    check("late_ack_req",  set_req, 0);

    vin.hsync = 1'b0; vin.rgb = 12'hABC;
    enable = 1'b1; tick();
    load(16'h0040, 16'h0030, 16'h0020, 16'h0808, 3);
    check("calc_busy", busy, 1);
    tick();
    check("draw_busy", busy, 0);
    check("draw_req",  set_req, 0);

    fld_data = 6'h00;
    probe("cov_back",  74, 58, BUTTON_BACK,  fa);
    probe("cov_white", 67, 49, BUTTON_WHITE, fa);
    probe("cov_gray",  65, 51, BUTTON_GRAY,  fa);
    fld_data = 6'h29;
    probe("mine", 170, 122, MINE_BLACK, fa);
    check("fld_addr_35", fa, 35);
    probe("outside", 10, 58, 12'hABC, fa);
    check("fa_hold", fa, 35);
    fld_data = 6'h10;
    probe("flag", 170, 122, FLAG_RED, fa);
    fld_data = 6'h23;
    probe("number", 170, 122, NUMBER_BLUE, fa);
    fld_data = 6'h25;
    probe("rev_border", 65, 51, REVEALED_GRAY, fa);
    check("fld_addr_0", fa, 0);

    enable = 1'b0; tick(); tick();
    enable = 1'b1; tick();
    load(16'h0040, 16'h0030, 16'h0020, 16'h1414, 0);
    tick(); tick();
    fld_data = 6'h00;
    probe("edge_in", 575, 58, BUTTON_WHITE, fa);
    check("edge_fa", fa, 15);
    probe("edge_out", 576, 58, 12'hABC, fa);

    enable = 1'b0; tick(); tick();
    enable = 1'b1; tick();
    check("abort_pre_req", set_req, 1);
    tick();
    enable = 1'b0; set_ack = 1'b1; set_rdata = 16'h0FFF;
    tick();
    set_ack = 1'b0; set_rdata = 16'h0;
    check("abort_req",  set_req, 0);
    check("abort_busy", busy, 0);
    tick();
    enable = 1'b1; tick();
    load(16'h0040, 16'h0030, 16'h0020, 16'h0808, 1);
    tick();
    probe("reload_back", 74, 58, BUTTON_BACK, fa);

    enable = 1'b0; tick();
    enable = 1'b1; tick();
    rst = 1'b1; tick();
    check("rst_load_req",  set_req, 0);
    check("rst_load_busy", busy, 0);
    rst = 1'b0; enable = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
